// File: rtl/vga_seq_pkg.sv
// Shared types and default bus widths for the VGA plot sequencer.
package vga_seq_pkg;
  localparam int DEF_X_W = 8;
  localparam int DEF_Y_W = 7;
  localparam int DEF_C_W = 3;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_GUARD, S_RUN, S_HOLD} state_t;
  typedef enum logic {HOLD_LAST, LOOP} mode_t;
endpackage

// File: rtl/vga_plot_sequencer_if.sv
// Client handshake lines plus the muxed bus towards the vga_adapter.
interface vga_plot_sequencer_if import vga_seq_pkg::*; #(
  parameter int NUM_CLIENTS = 2,
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W,
  parameter int C_W = DEF_C_W
);
  logic [NUM_CLIENTS-1:0]     cl_start;
  logic [NUM_CLIENTS-1:0]     cl_waitrequest;
  logic [NUM_CLIENTS-1:0]     cl_plot;
  logic [NUM_CLIENTS*X_W-1:0] cl_x;
  logic [NUM_CLIENTS*Y_W-1:0] cl_y;
  logic [NUM_CLIENTS*C_W-1:0] cl_colour;
  logic                       vga_plot;
  logic [X_W-1:0]             vga_x;
  logic [Y_W-1:0]             vga_y;
  logic [C_W-1:0]             vga_colour;

  modport master (
    output cl_start, vga_plot, vga_x, vga_y, vga_colour,
    input  cl_waitrequest, cl_plot, cl_x, cl_y, cl_colour
  );
  modport slave (
    input  cl_start, vga_plot, vga_x, vga_y, vga_colour,
    output cl_waitrequest, cl_plot, cl_x, cl_y, cl_colour
  );
endinterface

// File: rtl/vga_bus_mux.sv
// Indexed select of one client's plot/x/y/colour; all zero when not enabled.
module vga_bus_mux import vga_seq_pkg::*; #(
  parameter int NUM_CLIENTS = 2,
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W,
  parameter int C_W = DEF_C_W
) (
  input  logic                       en,
  input  logic [2:0]                 sel,
  input  logic [NUM_CLIENTS-1:0]     cl_plot,
  input  logic [NUM_CLIENTS*X_W-1:0] cl_x,
  input  logic [NUM_CLIENTS*Y_W-1:0] cl_y,
  input  logic [NUM_CLIENTS*C_W-1:0] cl_colour,
  output logic                       vga_plot,
  output logic [X_W-1:0]             vga_x,
  output logic [Y_W-1:0]             vga_y,
  output logic [C_W-1:0]             vga_colour
);
  always_comb begin
    vga_plot   = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (en && sel == 3'(i)) begin
        vga_plot   = cl_plot[i];
        vga_x      = cl_x[i*X_W +: X_W];
        vga_y      = cl_y[i*Y_W +: Y_W];
        vga_colour = cl_colour[i*C_W +: C_W];
      end
    end
  end
endmodule

// File: rtl/vga_plot_sequencer.sv
// Hands the VGA bus to drawing clients one after another (start/waitrequest handshake).
module vga_plot_sequencer import vga_seq_pkg::*; #(
  parameter int    NUM_CLIENTS = 2,
  parameter mode_t MODE        = HOLD_LAST,
  parameter int    X_W         = DEF_X_W,
  parameter int    Y_W         = DEF_Y_W,
  parameter int    C_W         = DEF_C_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        restart,
  vga_plot_sequencer_if.master bus,
  output logic [2:0]  active_client,
  output logic        busy,
  output logic [15:0] plot_count
);
  localparam logic [2:0] LAST = 3'(NUM_CLIENTS - 1);

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic       wr_sel;
  logic       bus_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      plot_count <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      // Clearing on LAUNCH entry wins over a plot on the last RUN cycle.
      if (restart || (state_n == S_LAUNCH && state != S_LAUNCH))
        plot_count <= '0;
      else if (bus.vga_plot && plot_count != 16'hFFFF)
        plot_count <= plot_count + 16'd1;
    end
  end

  always_comb begin
    wr_sel = 1'b1;
    for (int i = 0; i < NUM_CLIENTS; i++)
      if (idx == 3'(i)) wr_sel = bus.cl_waitrequest[i];

    state_n = state;
    idx_n   = idx;
    if (restart) begin
      state_n = S_IDLE;
      idx_n   = '0;
    end else begin
      case (state)
        S_IDLE:   if (go) begin state_n = S_LAUNCH; idx_n = '0; end
        S_LAUNCH: if (!wr_sel) state_n = S_GUARD;
        S_GUARD:  state_n = (MODE == HOLD_LAST && idx == LAST) ? S_HOLD : S_RUN;
        S_RUN: begin
          if (!wr_sel) begin
            if (idx != LAST) begin
              idx_n   = idx + 3'd1;
              state_n = S_LAUNCH;
            end else if (MODE == LOOP) begin
              idx_n   = '0;
              state_n = S_LAUNCH;
            end
          end
        end
        S_HOLD:   state_n = S_HOLD;
        default:  state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy          = (state != S_IDLE);
    bus_en        = (state == S_GUARD) || (state == S_RUN) || (state == S_HOLD);
    active_client = idx;
    for (int i = 0; i < NUM_CLIENTS; i++)
      bus.cl_start[i] = (state == S_LAUNCH) && (idx == 3'(i));
  end

  vga_bus_mux #(
    .NUM_CLIENTS(NUM_CLIENTS), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)
  ) u_mux (
    .en         (bus_en),
    .sel        (idx),
    .cl_plot    (bus.cl_plot),
    .cl_x       (bus.cl_x),
    .cl_y       (bus.cl_y),
    .cl_colour  (bus.cl_colour),
    .vga_plot   (bus.vga_plot),
    .vga_x      (bus.vga_x),
    .vga_y      (bus.vga_y),
    .vga_colour (bus.vga_colour)
  );
endmodule

// File: tb/tb_vga_plot_sequencer.sv
// Directed bench: a 2-client HOLD_LAST sequencer and a 3-client LOOP sequencer side by side.
module tb_vga_plot_sequencer;
  import vga_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic go_a = 1'b0, restart_a = 1'b0, go_b = 1'b0, restart_b = 1'b0;
  logic [2:0]  act_a, act_b;
  logic        busy_a, busy_b;
  logic [15:0] pc_a, pc_b;

  vga_plot_sequencer_if #(.NUM_CLIENTS(2)) bus_a ();
  vga_plot_sequencer_if #(.NUM_CLIENTS(3)) bus_b ();

  vga_plot_sequencer #(.NUM_CLIENTS(2), .MODE(HOLD_LAST)) dut_a (
    .clk(clk), .rst(rst), .go(go_a), .restart(restart_a), .bus(bus_a),
    .active_client(act_a), .busy(busy_a), .plot_count(pc_a)
  );
  vga_plot_sequencer #(.NUM_CLIENTS(3), .MODE(LOOP)) dut_b (
    .clk(clk), .rst(rst), .go(go_b), .restart(restart_b), .bus(bus_b),
    .active_client(act_b), .busy(busy_b), .plot_count(pc_b)
  );

  typedef struct {
    logic [1:0]  plot;
    logic [15:0] x;
    logic [13:0] y;
    logic [5:0]  c;
    logic [1:0]  wr;
    logic        e_plot;
    logic [7:0]  e_x;
    logic [6:0]  e_y;
    logic [2:0]  e_c;
  } vec_t;

  vec_t vecs [5];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bus_ok(input string nm, input logic ap, input logic [7:0] ax, input logic [6:0] ay,
                        input logic [2:0] ac, input logic ep, input logic [7:0] ex,
                        input logic [6:0] ey, input logic [2:0] ec);
    chk(nm, 32'({ap, ax, ay, ac}), 32'({ep, ex, ey, ec}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cl_a(input int k, input logic p, input logic [7:0] x, input logic [6:0] y,
                      input logic [2:0] c);
    bus_a.cl_plot[k]          = p;
    bus_a.cl_x[k*8 +: 8]      = x;
    bus_a.cl_y[k*7 +: 7]      = y;
    bus_a.cl_colour[k*3 +: 3] = c;
  endtask

  int   exp_pc;
  int   k;
  int   order [5];
  logic aborted;

  initial begin
    vecs[0] = '{2'b10, {8'd159, 8'd5},  {7'd119, 7'd6}, {3'd7, 3'd1}, 2'b00, 1'b1, 8'd159, 7'd119, 3'd7};
    vecs[1] = '{2'b01, {8'd20, 8'd30},  {7'd40, 7'd50}, {3'd2, 3'd4}, 2'b11, 1'b0, 8'd20,  7'd40,  3'd2};
    vecs[2] = '{2'b11, {8'd0, 8'd255},  {7'd0, 7'd127}, {3'd0, 3'd7}, 2'b10, 1'b1, 8'd0,   7'd0,   3'd0};
    vecs[3] = '{2'b00, {8'd85, 8'd170}, {7'd42, 7'd21}, {3'd5, 3'd2}, 2'b01, 1'b0, 8'd85,  7'd42,  3'd5};
    vecs[4] = '{2'b10, {8'd1, 8'd2},    {7'd3, 7'd4},   {3'd6, 3'd5}, 2'b11, 1'b1, 8'd1,   7'd3,   3'd6};
    order   = '{0, 1, 2, 0, 1};

    bus_a.cl_waitrequest = '1; bus_a.cl_plot = '1; bus_a.cl_x = '1; bus_a.cl_y = '1; bus_a.cl_colour = '1;
    bus_b.cl_waitrequest = '1; bus_b.cl_plot = '0; bus_b.cl_x = '0; bus_b.cl_y = '0; bus_b.cl_colour = '0;

    // Reset state, with clients driving junk that must not leak onto the bus.
    #1;
    chk("rst_busy_a", 32'(busy_a), 32'(0));
    chk("rst_start_a", 32'(bus_a.cl_start), 32'(0));
    chk("rst_count_a", 32'(pc_a), 32'(0));
    chk("rst_active_a", 32'(act_a), 32'(0));
    bus_ok("rst_bus_a", bus_a.vga_plot, bus_a.vga_x, bus_a.vga_y, bus_a.vga_colour, 1'b0, 8'd0, 7'd0, 3'd0);
    chk("rst_busy_b", 32'(busy_b), 32'(0));
    tick(); tick();
    rst = 1'b0;
    tick();
    #1;
    chk("idle_busy_a", 32'(busy_a), 32'(0));

    // 2 clients, HOLD_LAST: client0 accepts after 2 LAUNCH cycles, runs 11 RUN cycles.
    go_a = 1'b1;
    tick();
    cl_a(0, 1'b1, 8'd159, 7'd119, 3'd7);
    cl_a(1, 1'b1, 8'd1, 7'd2, 3'd3);
    #1;
    chk("a_launch_start", 32'(bus_a.cl_start), 32'(2'b01));
    chk("a_launch_busy", 32'(busy_a), 32'(1));
    chk("a_launch_active", 32'(act_a), 32'(0));
    bus_ok("a_launch_plot_masked", bus_a.vga_plot, bus_a.vga_x, bus_a.vga_y, bus_a.vga_colour, 1'b0, 8'd0, 7'd0, 3'd0);
    go_a = 1'b0;
    tick();
    #1 chk("a_launch_wait_start", 32'(bus_a.cl_start), 32'(2'b01));
    bus_a.cl_waitrequest[0] = 1'b0;
    tick();
    bus_a.cl_waitrequest[0] = 1'b1;
    #1;
    chk("a_guard_start", 32'(bus_a.cl_start), 32'(0));
    bus_ok("a_guard_bus", bus_a.vga_plot, bus_a.vga_x, bus_a.vga_y, bus_a.vga_colour, 1'b1, 8'd159, 7'd119, 3'd7);
    chk("a_guard_count", 32'(pc_a), 32'(0));
    exp_pc = 1;
    tick();
    for (int i = 0; i <= 10; i++) begin
      cl_a(0, 1'(i % 2), 8'(i * 15), 7'(i * 11), 3'(i));
      if (i == 10) bus_a.cl_waitrequest[0] = 1'b0;
      #1;
      bus_ok("a_run_bus", bus_a.vga_plot, bus_a.vga_x, bus_a.vga_y, bus_a.vga_colour,
             1'(i % 2), 8'(i * 15), 7'(i * 11), 3'(i));
      chk("a_run_count", 32'(pc_a), 32'(exp_pc));
      chk("a_run_start", 32'(bus_a.cl_start), 32'(0));
      if (i % 2 == 1) exp_pc++;
      tick();
    end
    #1;
    chk("a_launch1_start", 32'(bus_a.cl_start), 32'(2'b10));
    chk("a_launch1_active", 32'(act_a), 32'(1));
    chk("a_launch1_count", 32'(pc_a), 32'(0));
    bus_ok("a_launch1_bus", bus_a.vga_plot, bus_a.vga_x, bus_a.vga_y, bus_a.vga_colour, 1'b0, 8'd0, 7'd0, 3'd0);
    tick();
    bus_a.cl_waitrequest[1] = 1'b0;
    tick();
    #1;
    chk("a_guard1_start", 32'(bus_a.cl_start), 32'(0));
    bus_ok("a_guard1_bus", bus_a.vga_plot, bus_a.vga_x, bus_a.vga_y, bus_a.vga_colour, 1'b1, 8'd1, 7'd2, 3'd3);
    chk("a_guard1_count", 32'(pc_a), 32'(0));
    exp_pc = 1;
    tick();

    // HOLD: table of client patterns; waitrequest toggles must not move the state.
    for (int v = 0; v < 5; v++) begin
      bus_a.cl_plot        = vecs[v].plot;
      bus_a.cl_x           = vecs[v].x;
      bus_a.cl_y           = vecs[v].y;
      bus_a.cl_colour      = vecs[v].c;
      bus_a.cl_waitrequest = vecs[v].wr;
      #1;
      bus_ok("a_hold_bus", bus_a.vga_plot, bus_a.vga_x, bus_a.vga_y, bus_a.vga_colour,
             vecs[v].e_plot, vecs[v].e_x, vecs[v].e_y, vecs[v].e_c);
      chk("a_hold_active", 32'(act_a), 32'(1));
      chk("a_hold_busy", 32'(busy_a), 32'(1));
      chk("a_hold_start", 32'(bus_a.cl_start), 32'(0));
      chk("a_hold_count", 32'(pc_a), 32'(exp_pc));
      if (vecs[v].e_plot) exp_pc++;
      tick();
    end
    bus_a.cl_plot = '1;
    restart_a = 1'b1;
    tick();
    restart_a = 1'b0;
    #1;
    chk("a_restart_busy", 32'(busy_a), 32'(0));
    chk("a_restart_active", 32'(act_a), 32'(0));
    chk("a_restart_count", 32'(pc_a), 32'(0));
    bus_ok("a_restart_bus", bus_a.vga_plot, bus_a.vga_x, bus_a.vga_y, bus_a.vga_colour, 1'b0, 8'd0, 7'd0, 3'd0);

    // 3 clients, LOOP: immediate accept, 5 RUN cycles each, order 0,1,2,0 then restart in client1.
    for (int j = 0; j < 3; j++) begin
      bus_b.cl_x[j*8 +: 8]      = 8'(40 + j * 50);
      bus_b.cl_y[j*7 +: 7]      = 7'(10 + j * 30);
      bus_b.cl_colour[j*3 +: 3] = 3'(j + 1);
    end
    go_b = 1'b1;
    tick();
    aborted = 1'b0;
    for (int s = 0; s < 5 && !aborted; s++) begin
      k = order[s];
      bus_b.cl_plot = 3'(1 << k);
      #1;
      chk("b_launch_start", 32'(bus_b.cl_start), 32'(1 << k));
      chk("b_launch_active", 32'(act_b), 32'(k));
      chk("b_launch_count", 32'(pc_b), 32'(0));
      chk("b_launch_plot", 32'(bus_b.vga_plot), 32'(0));
      go_b = 1'b0;
      bus_b.cl_waitrequest = ~3'(1 << k);
      tick();
      #1 chk("b_guard_start", 32'(bus_b.cl_start), 32'(0));
      bus_b.cl_waitrequest = '1;
      tick();
      for (int i = 0; i < 5; i++) begin
        if (s == 4 && i == 2) begin
          restart_b = 1'b1;
          tick();
          restart_b = 1'b0;
          #1;
          chk("b_restart_busy", 32'(busy_b), 32'(0));
          chk("b_restart_start", 32'(bus_b.cl_start), 32'(0));
          chk("b_restart_active", 32'(act_b), 32'(0));
          chk("b_restart_count", 32'(pc_b), 32'(0));
          bus_ok("b_restart_bus", bus_b.vga_plot, bus_b.vga_x, bus_b.vga_y, bus_b.vga_colour, 1'b0, 8'd0, 7'd0, 3'd0);
          aborted = 1'b1;
          break;
        end
        if (i == 4) bus_b.cl_waitrequest = ~3'(1 << k);
        #1;
        chk("b_run_count", 32'(pc_b), 32'(i + 1));
        bus_ok("b_run_bus", bus_b.vga_plot, bus_b.vga_x, bus_b.vga_y, bus_b.vga_colour,
               1'b1, 8'(40 + k * 50), 7'(10 + k * 30), 3'(k + 1));
        tick();
      end
    end

    // Waitrequest low throughout: LAUNCH, GUARD, RUN one cycle each.
    bus_b.cl_waitrequest = '0;
    go_b = 1'b1;
    tick();
    #1 chk("b_fast_launch0", 32'(bus_b.cl_start), 32'(3'b001));
    go_b = 1'b0;
    tick();
    #1;
    chk("b_fast_guard_start", 32'(bus_b.cl_start), 32'(0));
    chk("b_fast_guard_active", 32'(act_b), 32'(0));
    tick();
    #1;
    chk("b_fast_run_start", 32'(bus_b.cl_start), 32'(0));
    chk("b_fast_run_active", 32'(act_b), 32'(0));
    tick();
    #1;
    chk("b_fast_launch1", 32'(bus_b.cl_start), 32'(3'b010));
    chk("b_fast_launch1_active", 32'(act_b), 32'(1));

    // Asynchronous reset in the middle of a LAUNCH cycle.
    bus_a.cl_waitrequest = '1;
    go_a = 1'b1;
    tick();
    #1 chk("a_async_pre_start", 32'(bus_a.cl_start), 32'(2'b01));
    #2 rst = 1'b1;
    #1;
    chk("a_async_start", 32'(bus_a.cl_start), 32'(0));
    chk("a_async_busy", 32'(busy_a), 32'(0));
    chk("a_async_active", 32'(act_a), 32'(0));
    chk("a_async_count", 32'(pc_a), 32'(0));
    bus_ok("a_async_bus", bus_a.vga_plot, bus_a.vga_x, bus_a.vga_y, bus_a.vga_colour, 1'b0, 8'd0, 7'd0, 3'd0);
    chk("b_async_start", 32'(bus_b.cl_start), 32'(0));
    chk("b_async_busy", 32'(busy_b), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
